psg_write_ctrl: RTL and testbench

- Upstream write sequencer for the TI SN76489-compatible PSG core; replaces direct switch drive of the PSG nWE/nCE/D pins.
- Buffers register bytes from a host (sound driver, ROM player or test bench) in a FIFO.
- Issues each byte to the PSG as a strobed write, aligned to the PSG clock-enable pulse and gated by the PSG READY handshake.

---
 rtl/psg_write_ctrl.sv | 145 ++++++++++++++
 tb/tb_psg_write_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_ctrl.sv
// psg_write_ctrl: FIFO-buffered, tick-aligned write sequencer for an SN76489-style PSG.
// Define PSG_WR_TIMEOUT_EN to abandon writes whose READY handshake exceeds TIMEOUT_TICKS.
module psg_write_ctrl #(
    parameter int FIFO_DEPTH    = 16,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic                        CLK100MHZ,
    input  logic                        CPU_RESETN,
    input  logic                        ti_clk_en,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    input  logic                        ti_READY,
    output logic                        ti_nCE,
    output logic                        ti_nWE,
    output logic [7:0]                  ti_D,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_DONE, RECOVER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    data_q, data_d;
    logic          strobe_q, strobe_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, empty, full;

`ifdef PSG_WR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] to_q, to_d;
    logic          terr_q, terr_d;
`endif

    always_comb begin
        empty    = level_q == '0;
        full     = level_q == (AW+1)'(FIFO_DEPTH);
        pop      = ti_clk_en && state_q == IDLE && !empty;
        wr_ready = !full || pop;
        push     = wr_valid && wr_ready;
        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop ? rptr_q + 1'b1 : rptr_q;
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d    = ovf_q || (wr_valid && !wr_ready);
        state_d  = state_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        gap_d    = gap_q;
        if (ti_clk_en) begin
            case (state_q)
                IDLE: if (!empty) begin
                    data_d  = mem_q[rptr_q];
                    state_d = SETUP;
                end
                SETUP: begin
                    strobe_d = 1'b1;
                    state_d  = STROBE;
                end
                STROBE: if (!ti_READY) state_d = WAIT_DONE;
                WAIT_DONE: if (ti_READY) begin
                    strobe_d = 1'b0;
                    gap_d    = '0;
                    state_d  = RECOVER;
                end
                RECOVER: if (gap_q == GW'(GAP_TICKS - 1)) state_d = IDLE;
                         else gap_d = gap_q + 1'b1;
                default: state_d = IDLE;
            endcase
        end
`ifdef PSG_WR_TIMEOUT_EN
        to_d   = to_q;
        terr_d = terr_q;
        // A handshake that completes on the expiry tick wins over the timeout.
        if (ti_clk_en) begin
            if (state_q == SETUP) to_d = '0;
            else if ((state_q == STROBE || state_q == WAIT_DONE) && state_d != RECOVER) begin
                if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
                    strobe_d = 1'b0;
                    gap_d    = '0;
                    state_d  = RECOVER;
                    terr_d   = 1'b1;
                end else to_d = to_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

`ifdef PSG_WR_TIMEOUT_EN
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            to_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            to_q   <= to_d;
            terr_q <= terr_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // strobe_q is the single source for both strobes so they can never split.
    assign ti_nCE     = !strobe_q;
    assign ti_nWE     = !strobe_q;
    assign ti_D       = data_q;
    assign busy       = !empty || state_q != IDLE;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_psg_write_ctrl.sv
// tb_psg_write_ctrl: randomized and directed checks of psg_write_ctrl against a
// tick-timeline reference model plus a small PSG READY responder.
module tb_psg_write_ctrl;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;
`ifdef PSG_WR_TIMEOUT_EN
    localparam int TMO   = 64;
`endif

    logic       clk = 0, rst_n = 0, tick = 0, wr_valid = 0, ready = 1;
    logic [7:0] wr_data = 0;
    logic       wr_ready, nce, nwe, busy, ovf, terr;
    logic [7:0] d;
    logic [4:0] level;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    psg_write_ctrl dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .ti_clk_en  (tick),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .ti_READY   (ready),
        .ti_nCE     (nce),
        .ti_nWE     (nwe),
        .ti_D       (d),
        .busy       (busy),
        .fifo_level (level),
        .overflow   (ovf),
        .timeout_err(terr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick generator and PSG responder; psg_mode 0 = pulse READY low per write,
    // 1 = hold READY low, 2 = READY stuck high.
    int tp = 28, tcnt = 0, psg_mode = 0, psg_lo = 1, lo_left = 0;
    bit acked = 0;
    initial forever begin
        @(negedge clk);
        if (psg_mode == 1) begin
            ready = 0; acked = 1; lo_left = 0;
        end else if (psg_mode == 2) begin
            ready = 1; lo_left = 0;
        end else if (lo_left > 0) begin
            if (tick) lo_left--;
            ready = (lo_left == 0);
        end else if (!nce && !acked) begin
            ready = 0; acked = 1;
            lo_left = psg_lo > 0 ? psg_lo : int'($urandom_range(1, 3));
        end else ready = 1;
        if (nce) acked = 0;
        tcnt = (tcnt + 1 >= tp) ? 0 : tcnt + 1;
        tick = (tcnt == 0);
    end

    // Reference model: a byte queue plus the phase of the write in progress,
    // advanced once per PSG tick.
    logic [7:0] mq[$];
    logic [7:0] strobed[$];
    logic [7:0] wlog[$];
    logic [7:0] m_d = 0;
    bit m_active = 0, m_setup = 0, m_low = 0, m_saw = 0, m_ovf = 0, m_terr = 0;
    int m_gap = 0;
`ifdef PSG_WR_TIMEOUT_EN
    int m_to = 0;
`endif

    task automatic model_reset();
        mq.delete();
        m_d = 0; m_active = 0; m_setup = 0; m_low = 0; m_saw = 0;
        m_ovf = 0; m_terr = 0; m_gap = 0;
    endtask

    task automatic model_step();
        bit pop_now, rdy;
        pop_now = tick && !m_active && mq.size() > 0;
        rdy     = mq.size() < DEPTH || pop_now;
        if (tick) begin
            if (pop_now) begin
                m_d = mq.pop_front(); m_active = 1; m_setup = 1;
            end else if (m_setup) begin
                m_setup = 0; m_low = 1; m_saw = 0;
`ifdef PSG_WR_TIMEOUT_EN
                m_to = 0;
`endif
                strobed.push_back(m_d);
            end else if (m_low) begin
                if (m_saw && ready) begin
                    m_low = 0; m_gap = GAP;
                end else begin
`ifdef PSG_WR_TIMEOUT_EN
                    m_to++;
                    if (m_to == TMO) begin
                        m_low = 0; m_gap = GAP; m_terr = 1;
                    end else if (!ready) m_saw = 1;
`else
                    if (!ready) m_saw = 1;
`endif
                end
            end else if (m_active) begin
                m_gap--;
                if (m_gap == 0) m_active = 0;
            end
        end
        if (wr_valid) begin
            if (rdy) mq.push_back(wr_data);
            else m_ovf = 1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle compare, write-log capture and level peak tracking.
    bit prev_nce = 1;
    int peak = 0;
    initial forever begin
        @(negedge clk);
        #2;
        chk("nce", nce, !m_low);
        chk("nwe", nwe, !m_low);
        chk("ti_d", d, m_d);
        chk("level", level, mq.size());
        chk("busy", busy, mq.size() > 0 || m_active);
        chk("wr_ready", wr_ready, mq.size() < DEPTH || (tick && !m_active && mq.size() > 0));
        chk("overflow", ovf, m_ovf);
        chk("timeout_err", terr, m_terr);
        if (prev_nce && !nce) wlog.push_back(d);
        prev_nce = nce;
        if (int'(level) > peak) peak = level;
    end

    function automatic logic sig(input int w);
        return w == 0 ? nce : (w == 1 ? busy : terr);
    endfunction

    task automatic wait_for(input string name, input int w, input logic v, input int lim);
        int n = 0;
        while (sig(w) !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, sig(w), v);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        wr_valid = 1; wr_data = b;
        @(negedge clk);
        wr_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cyc(2);
        rst_n = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] b0 [3];
        b0[0] = 8'h8E; b0[1] = 8'h0F; b0[2] = 8'h90;
        cyc(3);
        chk("rst_nce", nce, 1);
        chk("rst_nwe", nwe, 1);
        chk("rst_d", d, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_terr", terr, 0);
        rst_n = 1;
        cyc(3);

        // Single write, READY low for one tick.
        tp = 28; psg_lo = 1; psg_mode = 0;
        push(8'h8E);
        wait_for("t1_nce_low", 0, 0, 200);
        chk("t1_d", d, 8'h8E);
        n = 0;
        while (!nce && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t1_low_cycles", n, 2 * tp);
        wait_for("t1_idle", 1, 0, 500);

        // Back-to-back bytes at one tick per cycle.
        tp = 1; wlog.delete(); peak = 0;
        cyc(2);
        push(8'h8E); push(8'h0F); push(8'h90);
        wait_for("t2_idle", 1, 0, 200);
        chk("t2_count", wlog.size(), 3);
        for (int i = 0; i < 3; i++) chk("t2_order", wlog.size() > i ? wlog[i] : 8'hxx, b0[i]);
        chk("t2_peak", peak, 2);

        // Overflow while the handshake is held.
        tp = 4; psg_mode = 1;
        push(8'hA0);
        wait_for("t3_nce_low", 0, 0, 100);
        cyc(10);
        for (int i = 0; i < 17; i++) push(8'h10 + 8'(i));
        cyc(2);
        chk("t3_level", level, 16);
        chk("t3_wr_ready", wr_ready, 0);
        chk("t3_ovf", ovf, 1);
        wlog.delete();
        psg_mode = 0;
        wait_for("t3_idle", 1, 0, 2000);
        chk("t3_count", wlog.size(), 16);
        for (int i = 0; i < 16; i++) chk("t3_order", wlog.size() > i ? wlog[i] : 8'hxx, 8'h10 + 8'(i));

        // Push while full on the same cycle as the pop.
        do_reset();
        chk("t4_ovf_cleared", ovf, 0);
        tp = 8; psg_mode = 1;
        push(8'hB0);
        wait_for("t4_nce_low", 0, 0, 100);
        cyc(10);
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        chk("t4_full", level, 16);
        wlog.delete();
        psg_mode = 0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!wr_ready && n < 500);
        chk("t4_pop_seen", wr_ready, 1);
        wr_valid = 1; wr_data = 8'h55;
        @(negedge clk);
        wr_valid = 0;
        chk("t4_level", level, 16);
        chk("t4_ovf", ovf, 0);
        wait_for("t4_idle", 1, 0, 3000);
        chk("t4_count", wlog.size(), 17);
        for (int i = 0; i < 16; i++) chk("t4_order", wlog.size() > i ? wlog[i] : 8'hxx, 8'h40 + 8'(i));
        chk("t4_last", wlog.size() > 16 ? wlog[16] : 8'hxx, 8'h55);

        // Asynchronous reset during STROBE with five bytes queued.
        tp = 4; psg_mode = 2;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        wait_for("t5_nce_low", 0, 0, 100);
        cyc(3);
        #3;
        rst_n = 0;
        #1;
        chk("t5_nce", nce, 1);
        chk("t5_nwe", nwe, 1);
        chk("t5_level", level, 0);
        @(negedge clk);
        rst_n = 1;
        psg_mode = 0;
        wlog.delete();
        cyc(100);
        chk("t5_no_writes", wlog.size(), 0);
        chk("t5_busy", busy, 0);

`ifdef PSG_WR_TIMEOUT_EN
        // Handshake never starts: the byte is abandoned, the next one goes out.
        tp = 2; psg_mode = 2;
        push(8'hFF); push(8'h12);
        wait_for("t6_nce_low", 0, 0, 100);
        wait_for("t6_terr", 2, 1, 64 * 2 + 50);
        chk("t6_nce_high", nce, 1);
        psg_mode = 0;
        wlog.delete();
        wait_for("t6_idle", 1, 0, 500);
        chk("t6_count", wlog.size(), 1);
        chk("t6_next", wlog.size() > 0 ? wlog[0] : 8'hxx, 8'h12);
`else
        // Without the timeout the write waits indefinitely for READY.
        tp = 1; psg_mode = 2;
        push(8'hFF);
        wait_for("t6_nce_low", 0, 0, 100);
        cyc(200);
        chk("t6_still_low", nce, 0);
        chk("t6_terr", terr, 0);
        psg_mode = 0;
        wait_for("t6_idle", 1, 0, 500);
`endif

        // Randomized traffic against the model.
        do_reset();
        wlog.delete();
        strobed.delete();
        for (int s = 0; s < 40; s++) begin
            int pct;
            tp = $urandom_range(1, 6);
            psg_lo = $urandom_range(0, 3);
            psg_mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            pct = $urandom_range(5, 60);
            for (int c = 0; c < 150; c++) begin
                wr_valid = ($urandom_range(0, 99) < pct);
                wr_data = 8'($urandom);
                @(negedge clk);
            end
            wr_valid = 0;
        end
        psg_mode = 0;
        wait_for("t7_idle", 1, 0, 5000);
        chk("t7_count", wlog.size(), strobed.size());
        for (int i = 0; i < wlog.size() && i < strobed.size(); i++) chk("t7_order", wlog[i], strobed[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
